thread_pc_scheduler: RTL and testbench
======================================

# thread_pc_scheduler

Per-thread program-counter store and fetch-thread selector for the multithreaded CVA6 frontend. It holds one PC and one lifecycle state per hardware thread and picks the next thread to fetch with a round-robin arbiter. Each accepted fetch advances that thread's PC; redirects, halts, resumes and starts change it. It sits between the controller/commit redirect logic and the frontend fetch stage.

## Interface
- CVA6Cfg, config_pkg::cva6_cfg_empty: core configuration; VLEN taken from it.
- NUM_THREADS, CVA6Cfg.NUM_THREADS: hardware threads; legal values 1..16.
- FETCH_BYTES, 4: PC increment per accepted fetch.
- TID_W (localparam), max(1, $clog2(NUM_THREADS)): thread-id width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- boot_addr_i  in  VLEN  reset PC for all threads; sampled during reset.
- fetch_valid_o  out  1  at least one thread is RUNNING.
- fetch_tid_o  out  TID_W  selected thread.
- fetch_pc_o  out  VLEN  PC of the selected thread.
- fetch_ready_i  in  1  frontend accepts the fetch.
- redirect_i / redirect_tid_i / redirect_pc_i  in  1/TID_W/VLEN  load a new PC.
- halt_i / halt_tid_i  in  1/TID_W  RUNNING -> HALTED.
- resume_i / resume_tid_i  in  1/TID_W  HALTED -> RUNNING.
- start_i / start_tid_i / start_pc_i  in  1/TID_W/VLEN  DISABLED -> RUNNING with a new PC.
- pc_read_tid_i  in  TID_W  debug/CSR read select.
- pc_read_o  out  VLEN  PC of pc_read_tid_i; combinational.
- thread_state_o  out  NUM_THREADS x 2  per-thread state encoding.

## Operation
- States per thread: DISABLED (0), RUNNING (1), HALTED (2). Encoding 3 is unused and is never produced.
- Reset:
  - All PCs are set to boot_addr_i.
  - Thread 0 goes to RUNNING; threads 1..N-1 go to DISABLED.
  - The arbiter pointer is set to NUM_THREADS-1, so thread 0 is granted first.
- Arbitration:
  - The grant goes to the lowest-index RUNNING thread strictly after the pointer, wrapping round.
  - fetch_valid_o = |RUNNING.
  - With no thread RUNNING, fetch_tid_o is 0 and fetch_pc_o is the PC of thread 0.
- Handshake (fetch_valid_o & fetch_ready_i):
  - PC[tid] <= PC[tid] + FETCH_BYTES, modulo 2^VLEN; wrap-around is silent.
  - The pointer moves to tid.
  - With no handshake, the pointer holds.
- Redirect: PC[redirect_tid_i] <= redirect_pc_i whatever the thread's state. The state does not change.
- Halt: takes effect only from RUNNING. The PC is held.
- Resume: takes effect only from HALTED. The PC is unchanged.
- Start: takes effect only from DISABLED. The PC is loaded from start_pc_i.
- Any command that does not match the thread's current state is ignored.
- Same thread, same cycle, PC priority: start > redirect > fetch increment. The handshake is still consumed.
- Same thread, same cycle, state priority: halt > resume > start.
- Commands to different threads in the same cycle all apply in parallel.
- A tid >= NUM_THREADS on any input is ignored.
- While fetch_ready_i is low, fetch_tid_o and fetch_pc_o stay stable, with two exceptions:
  - a redirect to the selected thread changes fetch_pc_o on the next cycle;
  - a halt of the selected thread re-arbitrates and may drop fetch_valid_o.
  Both exceptions are permitted by the frontend.

## Timing
- Fetch outputs are combinational from registered state and PC. There are no input-to-output combinational paths except pc_read_tid_i -> pc_read_o.
- Every command updates state and PC on the next rising edge. Its effect is visible on the outputs in the following cycle.
- Asserting reset mid-operation returns all state immediately to the reset values above. fetch_valid_o = 1 during reset.
- Throughput: one fetch per cycle. With k threads RUNNING, each is granted once every k accepted fetches.

## Structure
- thread_pkg holds:
  - thread_state_e (2-bit enum);
  - the tid width function;
  - the THREAD_STATE_* constants, shared with the controller and the CSR file.
- Sub-module thread_rr_arbiter, parametrised on N, provides the request vector, pointer, grant index and grant-valid. It is reused by issue-side thread selection.
- This block contains the PC/state register arrays, the command decode and the priority logic.

## Test plan
- Reset with boot_addr_i=0x8000_0000, ready held at 1: fetch_pc_o is 0x8000_0000, 0x8000_0004, 0x8000_0008 on consecutive cycles, with tid 0 every cycle.
- Start tid1 at 0x1000 and tid3 at 0x3000, ready=1:
  - grant order is 0,1,3,0,1,3;
  - each thread's PC advances by 4 only on its own grants.
- ready=0 for 5 cycles with 3 threads RUNNING: tid and pc are constant and no PC changes. On the next ready cycle the same tid is accepted.
- Same cycle on tid1: handshake plus redirect to 0x2000. The next tid1 grant presents 0x2000, not the old PC+4.
- Halt while selected, then resume:
  - halt tid0 while it is selected with ready=0: next cycle selects tid1, and the PC of tid0 is frozen;
  - resume tid0: it rejoins the rotation after the current pointer;
  - halt all threads: fetch_valid_o=0.
- Illegal and edge cases:
  - start on a RUNNING thread and resume on a DISABLED thread are ignored;
  - redirect to 0xFFFF_FFFC followed by a handshake wraps the PC to 0 (VLEN=32);
  - reset asserted mid-rotation restores tid0 RUNNING at boot_addr_i.

Source files
------------

// File: rtl/config_pkg.sv
// config_pkg: minimal core-configuration slice carrying the fields this block consumes.
package config_pkg;

  typedef struct packed {
    int unsigned VLEN;
    int unsigned NUM_THREADS;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{VLEN: 32, NUM_THREADS: 4};

endpackage

// File: rtl/thread_pkg.sv
// thread_pkg: thread lifecycle encoding and thread-id width helper shared with controller and CSR file.
package thread_pkg;

  typedef enum logic [1:0] {
    THREAD_DISABLED = 2'd0,
    THREAD_RUNNING  = 2'd1,
    THREAD_HALTED   = 2'd2
  } thread_state_e;

  localparam logic [1:0] THREAD_STATE_DISABLED = 2'd0;
  localparam logic [1:0] THREAD_STATE_RUNNING  = 2'd1;
  localparam logic [1:0] THREAD_STATE_HALTED   = 2'd2;

  function automatic int unsigned tid_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/thread_rr_arbiter.sv
// thread_rr_arbiter: round-robin grant over N thread requests.
//   clk_i/rst_ni  clock, async active-low reset (pointer resets to N-1 so index 0 wins first)
//   req_i         per-thread request vector
//   advance_i     consumer accepted the grant; pointer moves to the granted index
//   gnt_idx_o     lowest requesting index strictly after the pointer, wrapping; 0 when idle
//   gnt_valid_o   any request present
module thread_rr_arbiter
  import thread_pkg::*;
#(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = tid_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [N-1:0]  req_i,
  input  logic          advance_i,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  logic [IW-1:0] ptr_q, ptr_d, idx;
  logic          found;

  assign gnt_valid_o = |req_i;
  assign ptr_d       = (advance_i && gnt_valid_o) ? gnt_idx_o : ptr_q;

  // Scan offsets 1..N so the pointer's own index is considered last.
  always_comb begin
    gnt_idx_o = '0;
    found     = 1'b0;
    idx       = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = IW'((32'(ptr_q) + i) % N);
      if (!found && req_i[idx]) begin
        gnt_idx_o = idx;
        found     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) ptr_q <= IW'(N - 1);
    else         ptr_q <= ptr_d;
  end

endmodule

// File: rtl/thread_pc_scheduler.sv
// thread_pc_scheduler: per-thread PC/state store with round-robin fetch-thread selection.
//   clk_i/rst_ni        clock, async active-low reset (all PCs <- boot_addr_i, thread 0 RUNNING)
//   fetch_*             selected thread and its PC; PC advances by FETCH_BYTES on valid&ready
//   redirect_*          load a PC into any thread regardless of state
//   halt_*/resume_*     RUNNING->HALTED / HALTED->RUNNING
//   start_*             DISABLED->RUNNING with a new PC
//   pc_read_tid_i/_o    combinational PC read port
//   thread_state_o      per-thread 2-bit state
module thread_pc_scheduler
  import thread_pkg::*;
#(
  parameter  config_pkg::cva6_cfg_t CVA6Cfg     = config_pkg::cva6_cfg_empty,
  parameter  int unsigned           NUM_THREADS = CVA6Cfg.NUM_THREADS,
  parameter  int unsigned           FETCH_BYTES = 4,
  localparam int unsigned           VLEN        = CVA6Cfg.VLEN,
  localparam int unsigned           TID_W       = tid_width(NUM_THREADS)
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [VLEN-1:0]             boot_addr_i,
  output logic                        fetch_valid_o,
  output logic [TID_W-1:0]            fetch_tid_o,
  output logic [VLEN-1:0]             fetch_pc_o,
  input  logic                        fetch_ready_i,
  input  logic                        redirect_i,
  input  logic [TID_W-1:0]            redirect_tid_i,
  input  logic [VLEN-1:0]             redirect_pc_i,
  input  logic                        halt_i,
  input  logic [TID_W-1:0]            halt_tid_i,
  input  logic                        resume_i,
  input  logic [TID_W-1:0]            resume_tid_i,
  input  logic                        start_i,
  input  logic [TID_W-1:0]            start_tid_i,
  input  logic [VLEN-1:0]             start_pc_i,
  input  logic [TID_W-1:0]            pc_read_tid_i,
  output logic [VLEN-1:0]             pc_read_o,
  output logic [NUM_THREADS-1:0][1:0] thread_state_o
);

  thread_state_e          st_q [NUM_THREADS];
  thread_state_e          st_d [NUM_THREADS];
  logic [VLEN-1:0]        pc_q [NUM_THREADS];
  logic [VLEN-1:0]        pc_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] running, halt_hit, resume_hit, start_hit;
  logic                   hs;

  thread_rr_arbiter #(.N(NUM_THREADS)) u_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (running),
    .advance_i  (fetch_ready_i),
    .gnt_idx_o  (fetch_tid_o),
    .gnt_valid_o(fetch_valid_o)
  );

  assign hs         = fetch_valid_o & fetch_ready_i;
  assign fetch_pc_o = pc_q[fetch_tid_o];
  assign pc_read_o  = (32'(pc_read_tid_i) < NUM_THREADS) ? pc_q[pc_read_tid_i] : '0;

  // Each command is gated by the state it leaves, so at most one state change
  // can hit a thread per cycle; tids >= NUM_THREADS never match any t.
  always_comb begin
    for (int unsigned t = 0; t < NUM_THREADS; t++) begin
      running[t]        = st_q[t] == THREAD_RUNNING;
      thread_state_o[t] = st_q[t];
      halt_hit[t]       = halt_i   && halt_tid_i   == TID_W'(t) && st_q[t] == THREAD_RUNNING;
      resume_hit[t]     = resume_i && resume_tid_i == TID_W'(t) && st_q[t] == THREAD_HALTED;
      start_hit[t]      = start_i  && start_tid_i  == TID_W'(t) && st_q[t] == THREAD_DISABLED;
      st_d[t]           = halt_hit[t] ? THREAD_HALTED :
                          (resume_hit[t] || start_hit[t]) ? THREAD_RUNNING : st_q[t];
      pc_d[t]           = start_hit[t] ? start_pc_i :
                          (redirect_i && redirect_tid_i == TID_W'(t)) ? redirect_pc_i :
                          (hs && fetch_tid_o == TID_W'(t)) ? pc_q[t] + VLEN'(FETCH_BYTES) : pc_q[t];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned t = 0; t < NUM_THREADS; t++) begin
        st_q[t] <= (t == 0) ? THREAD_RUNNING : THREAD_DISABLED;
        pc_q[t] <= boot_addr_i;
      end
    end else begin
      st_q <= st_d;
      pc_q <= pc_d;
    end
  end

endmodule

// File: tb/tb_thread_pc_scheduler.sv
// tb_thread_pc_scheduler: directed vectors with hand-computed expectations (4 threads, VLEN=32).
module tb_thread_pc_scheduler;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [31:0] boot_addr_i;
  logic        fetch_valid_o;
  logic [1:0]  fetch_tid_o;
  logic [31:0] fetch_pc_o;
  logic        fetch_ready_i;
  logic        redirect_i, halt_i, resume_i, start_i;
  logic [1:0]  redirect_tid_i, halt_tid_i, resume_tid_i, start_tid_i, pc_read_tid_i;
  logic [31:0] redirect_pc_i, start_pc_i, pc_read_o;
  logic [3:0][1:0] thread_state_o;
  int n_vec = 0;
  int n_err = 0;

  thread_pc_scheduler dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .boot_addr_i(boot_addr_i),
    .fetch_valid_o(fetch_valid_o), .fetch_tid_o(fetch_tid_o), .fetch_pc_o(fetch_pc_o),
    .fetch_ready_i(fetch_ready_i),
    .redirect_i(redirect_i), .redirect_tid_i(redirect_tid_i), .redirect_pc_i(redirect_pc_i),
    .halt_i(halt_i), .halt_tid_i(halt_tid_i),
    .resume_i(resume_i), .resume_tid_i(resume_tid_i),
    .start_i(start_i), .start_tid_i(start_tid_i), .start_pc_i(start_pc_i),
    .pc_read_tid_i(pc_read_tid_i), .pc_read_o(pc_read_o), .thread_state_o(thread_state_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic fetch_is(input string tag, input logic [1:0] tid, input logic [31:0] pc);
    check({tag, ".valid"}, 64'(fetch_valid_o), 64'(1));
    check({tag, ".tid"}, 64'(fetch_tid_o), 64'(tid));
    check({tag, ".pc"}, 64'(fetch_pc_o), 64'(pc));
  endtask

  task automatic rd(input string tag, input logic [1:0] tid, input logic [31:0] exp);
    pc_read_tid_i = tid;
    #1;
    check(tag, 64'(pc_read_o), 64'(exp));
  endtask

  task automatic cmds_off;
    redirect_i = 0; halt_i = 0; resume_i = 0; start_i = 0;
  endtask

  initial begin
    rst_ni = 0; boot_addr_i = 32'h8000_0000; fetch_ready_i = 1; pc_read_tid_i = 0;
    redirect_tid_i = 0; halt_tid_i = 0; resume_tid_i = 0; start_tid_i = 0;
    redirect_pc_i = 0; start_pc_i = 0;
    cmds_off();
    tick(); tick();
    fetch_is("rst", 2'd0, 32'h8000_0000);
    check("rst.state", 64'(thread_state_o), 64'h01);
    rd("rst.pc2", 2'd2, 32'h8000_0000);
    rst_ni = 1;
    #1 fetch_is("boot0", 2'd0, 32'h8000_0000);
    tick(); fetch_is("boot1", 2'd0, 32'h8000_0004);
    tick(); fetch_is("boot2", 2'd0, 32'h8000_0008);
    fetch_ready_i = 0; start_i = 1; start_tid_i = 1; start_pc_i = 32'h1000;
    tick(); start_tid_i = 3; start_pc_i = 32'h3000;
    tick(); cmds_off();
    check("start.state", 64'(thread_state_o), 64'h45);
    fetch_ready_i = 1;
    fetch_is("rr0", 2'd1, 32'h1000);
    tick(); fetch_is("rr1", 2'd3, 32'h3000);
    tick(); fetch_is("rr2", 2'd0, 32'h8000_0008);
    tick(); fetch_is("rr3", 2'd1, 32'h1004);
    tick(); fetch_is("rr4", 2'd3, 32'h3004);
    tick(); fetch_is("rr5", 2'd0, 32'h8000_000C);
    rd("rr.pc2_untouched", 2'd2, 32'h8000_0000);
    fetch_ready_i = 0;
    for (int i = 0; i < 5; i++) begin
      tick(); fetch_is("stall", 2'd0, 32'h8000_000C);
    end
    rd("stall.pc1", 2'd1, 32'h1008);
    rd("stall.pc3", 2'd3, 32'h3008);
    fetch_ready_i = 1;
    tick(); fetch_is("unstall", 2'd1, 32'h1008);
    rd("unstall.pc0", 2'd0, 32'h8000_0010);
    redirect_i = 1; redirect_tid_i = 1; redirect_pc_i = 32'h2000;
    tick(); cmds_off();
    fetch_is("redir0", 2'd3, 32'h3008);
    rd("redir.pc1", 2'd1, 32'h2000);
    tick(); fetch_is("redir1", 2'd0, 32'h8000_0010);
    tick(); fetch_is("redir2", 2'd1, 32'h2000);
    tick(); fetch_is("redir3", 2'd3, 32'h300C);
    tick(); fetch_is("redir4", 2'd0, 32'h8000_0014);
    fetch_ready_i = 0; halt_i = 1; halt_tid_i = 0;
    tick(); cmds_off();
    fetch_is("halt", 2'd1, 32'h2004);
    check("halt.state", 64'(thread_state_o), 64'h46);
    rd("halt.pc0", 2'd0, 32'h8000_0014);
    resume_i = 1; resume_tid_i = 0;
    tick(); cmds_off();
    fetch_is("resume", 2'd0, 32'h8000_0014);
    start_i = 1; start_tid_i = 1; start_pc_i = 32'h5555;
    resume_i = 1; resume_tid_i = 2;
    tick(); cmds_off();
    check("illegal.state", 64'(thread_state_o), 64'h45);
    rd("illegal.pc1", 2'd1, 32'h2004);
    fetch_is("illegal", 2'd0, 32'h8000_0014);
    start_i = 1; start_tid_i = 2; start_pc_i = 32'h6000;
    redirect_i = 1; redirect_tid_i = 2; redirect_pc_i = 32'h7000;
    tick(); cmds_off();
    rd("prio.pc2", 2'd2, 32'h6000);
    check("prio.state", 64'(thread_state_o), 64'h55);
    redirect_i = 1; redirect_tid_i = 0; redirect_pc_i = 32'hFFFF_FFFC;
    tick(); cmds_off();
    fetch_is("wrap0", 2'd0, 32'hFFFF_FFFC);
    fetch_ready_i = 1;
    tick(); fetch_ready_i = 0;
    fetch_is("wrap1", 2'd1, 32'h2004);
    rd("wrap.pc0", 2'd0, 32'h0);
    for (int t = 0; t < 4; t++) begin
      halt_i = 1; halt_tid_i = 2'(t);
      tick();
    end
    cmds_off();
    check("allhalt.valid", 64'(fetch_valid_o), 64'(0));
    check("allhalt.tid", 64'(fetch_tid_o), 64'(0));
    check("allhalt.pc", 64'(fetch_pc_o), 64'(0));
    check("allhalt.state", 64'(thread_state_o), 64'hAA);
    resume_i = 1; resume_tid_i = 1; fetch_ready_i = 1;
    tick(); cmds_off();
    fetch_is("mid", 2'd1, 32'h2004);
    tick();
    boot_addr_i = 32'h4000;
    #2 rst_ni = 0;
    #1 fetch_is("midrst", 2'd0, 32'h4000);
    check("midrst.state", 64'(thread_state_o), 64'h01);
    tick(); rst_ni = 1;
    tick(); fetch_is("postrst", 2'd0, 32'h4004);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
